// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit that owns the HI/LO pair: shift-add multiply and
// restoring divide on operand magnitudes, STEP bits per cycle, signs restored in FIX.
module mdu_iterative #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int N     = WIDTH / STEP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [2:0] OP_MTHI = 3'b110;
    localparam logic [2:0] OP_MTLO = 3'b111;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic               mt_pend;
    logic               accept;
    logic               a_neg;
    logic               b_neg;
    logic               is_div_q;
    logic               is_madd_q;
    logic               dz_q;
    logic               neg_lo_q;
    logic               neg_hi_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   mag_q;
    logic [2*WIDTH-1:0] work_q;
    logic [2*WIDTH-1:0] step_w;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic neg);
        return neg ? $unsigned(-v) : $unsigned(v);
    endfunction

    // work = {partial product, remaining multiplier bits}; carry lands in the MSB on shift
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] w,
                                                    input logic [WIDTH-1:0] m);
        logic [2*WIDTH-1:0] acc;
        logic [WIDTH:0]     sum;
        acc = w;
        for (int i = 0; i < STEP; i++) begin
            sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
            acc = {sum, acc[WIDTH-1:1]};
        end
        return acc;
    endfunction

    // work = {partial remainder, dividend bits shifting out / quotient bits shifting in}
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] w,
                                                    input logic [WIDTH-1:0] m);
        logic [2*WIDTH-1:0] acc;
        logic [WIDTH:0]     sh;
        logic               qb;
        acc = w;
        for (int i = 0; i < STEP; i++) begin
            sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
            qb = (sh >= {1'b0, m});
            if (qb) sh = sh - {1'b0, m};
            acc = {sh[WIDTH-1:0], acc[WIDTH-2:0], qb};
        end
        return acc;
    endfunction

    assign accept = start && (state == S_IDLE);
    assign a_neg  = !op[0] && a[WIDTH-1];
    assign b_neg  = !op[0] && b[WIDTH-1];
    assign busy   = (state != S_IDLE);

    always_comb begin
        step_w = is_div_q ? div_step(work_q, mag_q) : mul_step(work_q, mag_q);
        prod   = neg_lo_q ? -work_q : work_q;
        quo    = work_q[WIDTH-1:0];
        rem    = work_q[2*WIDTH-1:WIDTH];
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (dz_q) begin
            res_hi = a_q;
            res_lo = '1;
        end else if (is_div_q) begin
            res_lo = neg_lo_q ? -quo : quo;
            res_hi = neg_hi_q ? -rem : rem;
        end else if (is_madd_q) begin
            {res_hi, res_lo} = {hi, lo} + prod;
        end
    end

    // Control and architectural HI/LO state
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            mt_pend     <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done    <= mt_pend;
            mt_pend <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        cnt         <= '0;
                        if (op == OP_MTHI) begin
                            hi      <= a;
                            mt_pend <= 1'b1;
                        end else if (op == OP_MTLO) begin
                            lo      <= a;
                            mt_pend <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) state <= S_FIX;
                end
                S_FIX: begin
                    hi          <= res_hi;
                    lo          <= res_lo;
                    div_by_zero <= dz_q;
                    done        <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand capture at acceptance, then iteration
    always_ff @(posedge clk) begin
        if (accept) begin
            is_div_q  <= op[2];
            is_madd_q <= (op[2:1] == 2'b01);
            dz_q      <= op[2] && (b == '0);
            a_q       <= a;
            neg_lo_q  <= a_neg ^ b_neg;
            neg_hi_q  <= a_neg;
            if (op[2]) begin
                work_q <= {{WIDTH{1'b0}}, magnitude($signed(a), a_neg)};
                mag_q  <= magnitude($signed(b), b_neg);
            end else begin
                work_q <= {{WIDTH{1'b0}}, magnitude($signed(b), b_neg)};
                mag_q  <= magnitude($signed(a), a_neg);
            end
        end else if (state == S_RUN) begin
            work_q <= step_w;
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: STEP=1/2/4 instances, directed vectors, randomized ops
// against an arithmetic reference model, plus handshake and reset corner cases.
module tb_mdu_iterative;
    localparam int NDUT = 3;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        start [NDUT];
    logic [2:0]  op    [NDUT];
    logic [31:0] a     [NDUT];
    logic [31:0] b     [NDUT];
    logic        busy  [NDUT];
    logic        done  [NDUT];
    logic        dz    [NDUT];
    logic [31:0] hi    [NDUT];
    logic [31:0] lo    [NDUT];

    logic [31:0] mdl_hi [NDUT];
    logic [31:0] mdl_lo [NDUT];
    logic        mdl_dz [NDUT];

    vec_t tbl [14];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mdu_iterative #(.WIDTH(32), .STEP(1 << g)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start[g]),
            .op          (op[g]),
            .a           (a[g]),
            .b           (b[g]),
            .busy        (busy[g]),
            .done        (done[g]),
            .hi          (hi[g]),
            .lo          (lo[g]),
            .div_by_zero (dz[g])
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: the architectural effect of one operation on HI/LO and the flag
    task automatic model_apply(input int d, input logic [2:0] o, input logic [31:0] av,
                               input logic [31:0] bv);
        longint      sp;
        logic [63:0] up;
        logic [63:0] acc;
        int          sa;
        int          sb;
        sa = av;
        sb = bv;
        mdl_dz[d] = 1'b0;
        acc = {mdl_hi[d], mdl_lo[d]};
        sp  = longint'(sa) * longint'(sb);
        up  = {32'd0, av} * {32'd0, bv};
        case (o)
            3'd0: acc = sp;
            3'd1: acc = up;
            3'd2: acc = acc + sp;
            3'd3: acc = acc + up;
            3'd4, 3'd5: begin
                if (bv == 32'd0) begin
                    acc = {av, 32'hFFFF_FFFF};
                    mdl_dz[d] = 1'b1;
                end else if (o == 3'd5) begin
                    acc = {av % bv, av / bv};
                end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
                    acc = {32'd0, 32'h8000_0000};
                end else begin
                    acc = {32'(sa % sb), 32'(sa / sb)};
                end
            end
            3'd6: acc[63:32] = av;
            default: acc[31:0] = av;
        endcase
        {mdl_hi[d], mdl_lo[d]} = acc;
    endtask

    // Issue one op, follow it to done, compare latency and results with the model.
    // immediate: drive start now (used from a done cycle); pulse: re-pulse start while busy.
    task automatic do_op(input int d, input logic [2:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input bit immediate, input bit pulse);
        int k;
        int exp_lat;
        if (!immediate) @(negedge clk);
        start[d] = 1'b1;
        op[d]    = o;
        a[d]     = av;
        b[d]     = bv;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        op[d]    = 3'($urandom);
        a[d]     = $urandom;
        b[d]     = $urandom;
        model_apply(d, o, av, bv);
        exp_lat = (o[2:1] == 2'b11) ? 1 : (32 >> d) + 1;
        check($sformatf("d%0d op%0d busy_at_accept", d, o), 64'(busy[d]), 64'(o[2:1] != 2'b11));
        k = 0;
        while (!done[d] && k < 64) begin
            start[d] = pulse && (k == 3);
            @(posedge clk);
            #1;
            k++;
        end
        start[d] = 1'b0;
        check($sformatf("d%0d op%0d latency", d, o), 64'(k), 64'(exp_lat));
        check($sformatf("d%0d op%0d busy_in_done", d, o), 64'(busy[d]), 64'd0);
        check($sformatf("d%0d op%0d hi", d, o), 64'(hi[d]), 64'(mdl_hi[d]));
        check($sformatf("d%0d op%0d lo", d, o), 64'(lo[d]), 64'(mdl_lo[d]));
        check($sformatf("d%0d op%0d div_by_zero", d, o), 64'(dz[d]), 64'(mdl_dz[d]));
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        int nd;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        tbl[0]  = '{3'd0, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        tbl[1]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
        tbl[2]  = '{3'd6, 32'd0,         32'd0,          32'h0000_0000, 32'hFFFF_FFFE, 1'b0};
        tbl[3]  = '{3'd7, 32'd10,        32'd0,          32'h0000_0000, 32'h0000_000A, 1'b0};
        tbl[4]  = '{3'd2, 32'd4,         32'd5,          32'h0000_0000, 32'h0000_001E, 1'b0};
        tbl[5]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_001F, 1'b0};
        tbl[6]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[7]  = '{3'd5, 32'd7,         32'd2,          32'h0000_0001, 32'h0000_0003, 1'b0};
        tbl[8]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0};
        tbl[9]  = '{3'd5, 32'h0000_1234, 32'd0,          32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
        tbl[10] = '{3'd7, 32'h0000_0055, 32'd0,          32'h0000_1234, 32'h0000_0055, 1'b0};
        tbl[11] = '{3'd4, 32'd7,         32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        tbl[12] = '{3'd4, 32'hFFFF_FFF0, 32'd0,          32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1};
        tbl[13] = '{3'd2, 32'hFFFF_FFFF, 32'd3,          32'hFFFF_FFF0, 32'hFFFF_FFFC, 1'b0};

        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            start[d]  = 1'b0;
            op[d]     = 3'd0;
            a[d]      = 32'd0;
            b[d]      = 32'd0;
            mdl_hi[d] = 32'd0;
            mdl_lo[d] = 32'd0;
            mdl_dz[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("d%0d reset busy", d), 64'(busy[d]), 64'd0);
            check($sformatf("d%0d reset done", d), 64'(done[d]), 64'd0);
            check($sformatf("d%0d reset hi", d), 64'(hi[d]), 64'd0);
            check($sformatf("d%0d reset lo", d), 64'(lo[d]), 64'd0);
            check($sformatf("d%0d reset dz", d), 64'(dz[d]), 64'd0);
        end
        rst = 1'b0;

        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 14; i++) begin
                do_op(d, tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 1'b0);
                check($sformatf("d%0d vec%0d hi", d, i), 64'(hi[d]), 64'(tbl[i].hi));
                check($sformatf("d%0d vec%0d lo", d, i), 64'(lo[d]), 64'(tbl[i].lo));
                check($sformatf("d%0d vec%0d dz", d, i), 64'(dz[d]), 64'(tbl[i].dz));
                @(posedge clk);
                #1;
                check($sformatf("d%0d vec%0d done_pulse", d, i), 64'(done[d]), 64'd0);
            end
        end

        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 40; i++) begin
                ro = 3'($urandom_range(0, 7));
                ra = $urandom;
                rb = $urandom;
                case ($urandom_range(0, 7))
                    0: rb = 32'd0;
                    1: begin
                        ra = 32'h8000_0000;
                        rb = 32'hFFFF_FFFF;
                    end
                    2: rb = 32'($urandom_range(1, 15));
                    default: ;
                endcase
                do_op(d, ro, ra, rb, 1'b0, 1'b0);
            end
        end

        // Start re-pulsed while busy must be dropped; then back-to-back starts from done cycles
        do_op(0, 3'd4, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b1);
        do_op(0, 3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);
        do_op(0, 3'd6, 32'hCAFE_F00D, 32'd0, 1'b1, 1'b0);
        do_op(0, 3'd3, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0);
        do_op(0, 3'd5, 32'd99, 32'd0, 1'b1, 1'b0);

        // Reset in the middle of a multiply aborts it without any HI/LO write or done
        @(negedge clk);
        start[0] = 1'b1;
        op[0]    = 3'd0;
        a[0]     = 32'h0000_1234;
        b[0]     = 32'h0000_5678;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            mdl_hi[d] = 32'd0;
            mdl_lo[d] = 32'd0;
            mdl_dz[d] = 1'b0;
            check($sformatf("d%0d midrun_reset hi", d), 64'(hi[d]), 64'd0);
            check($sformatf("d%0d midrun_reset lo", d), 64'(lo[d]), 64'd0);
        end
        check("midrun_reset busy", 64'(busy[0]), 64'd0);
        check("midrun_reset dz", 64'(dz[0]), 64'd0);
        nd = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (done[0]) nd++;
        end
        check("midrun_reset no_done", 64'(nd), 64'd0);
        check("midrun_reset hi_held", 64'(hi[0]), 64'd0);
        do_op(0, 3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
